// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single memory_unit port between NUM_REQ requesters.
// Optional MEM_ARB_LOCK_EN adds a per-requester lock that keeps ownership across transactions.
module mem_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [2*NUM_REQ-1:0]      req_func,
   input  logic [ADDR_W*NUM_REQ-1:0] req_address,
   input  logic [DATA_W*NUM_REQ-1:0] req_write_data,
`ifdef MEM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        lock,
`endif
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rd_data,
   output logic [1:0]                mem_func,
   output logic                      mem_execute,
   output logic [ADDR_W-1:0]         mem_address,
   output logic [DATA_W-1:0]         mem_write_data,
   input  logic                      mem_ready,
   input  logic [DATA_W-1:0]         mem_read_data,
   output logic                      busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] rr_ptr, owner, pick, sel, owner_nx;
   logic          found, take, finish;
`ifdef MEM_ARB_LOCK_EN
   logic          locked, unlock;
`endif

   function automatic logic [PW-1:0] wrap(input int v);
      return (v >= NUM_REQ) ? PW'(v - NUM_REQ) : PW'(v);
   endfunction

   // Descending scan so the last hit is the first set bit at or after rr_ptr.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[wrap(int'(rr_ptr) + i)]) begin
            found = 1'b1;
            pick  = wrap(int'(rr_ptr) + i);
         end
      end
   end

   assign owner_nx = wrap(int'(owner) + 1);

   always_comb begin
      state_nx = state;
      take     = 1'b0;
      finish   = 1'b0;
      sel      = pick;
`ifdef MEM_ARB_LOCK_EN
      unlock   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
`ifdef MEM_ARB_LOCK_EN
            if (locked) begin
               sel = owner;
               if (!lock[owner])
                  unlock = 1'b1;
               else if (mem_ready && req[owner])
                  take = 1'b1;
            end else if (mem_ready && found) begin
               take = 1'b1;
            end
`else
            if (mem_ready && found)
               take = 1'b1;
`endif
            if (take)
               state_nx = ISSUE;
         end
         ISSUE:     state_nx = WAIT_BUSY;
         WAIT_BUSY: if (!mem_ready) state_nx = WAIT_DONE;
         WAIT_DONE: begin
            if (mem_ready) begin
               finish   = 1'b1;
               state_nx = IDLE;
            end
         end
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         owner          <= '0;
         grant          <= '0;
         done           <= '0;
         rd_data        <= '0;
         mem_func       <= '0;
         mem_address    <= '0;
         mem_write_data <= '0;
`ifdef MEM_ARB_LOCK_EN
         locked         <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         done  <= '0;
         if (take) begin
            owner          <= sel;
            grant          <= NUM_REQ'(1) << sel;
            mem_func       <= req_func[2*sel +: 2];
            mem_address    <= req_address[ADDR_W*sel +: ADDR_W];
            mem_write_data <= req_write_data[DATA_W*sel +: DATA_W];
         end
         if (finish) begin
            rd_data <= mem_read_data;
            done    <= grant;
`ifdef MEM_ARB_LOCK_EN
            if (lock[owner]) begin
               locked <= 1'b1;
            end else begin
               grant  <= '0;
               rr_ptr <= owner_nx;
            end
`else
            grant  <= '0;
            rr_ptr <= owner_nx;
`endif
         end
`ifdef MEM_ARB_LOCK_EN
         if (unlock) begin
            locked <= 1'b0;
            grant  <= '0;
            rr_ptr <= owner_nx;
         end
`endif
      end
   end

   assign mem_execute = (state == ISSUE);
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, contention, rotation, not-ready, reset, lock.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [5:0]  req_func;
   logic [35:0] req_address;
   logic [47:0] req_write_data;
   logic [2:0]  grant, done;
   logic [15:0] rd_data;
   logic [1:0]  mem_func;
   logic        mem_execute;
   logic [11:0] mem_address;
   logic [15:0] mem_write_data;
   logic        mem_ready;
   logic [15:0] mem_read_data;
   logic        busy;
`ifdef MEM_ARB_LOCK_EN
   logic [2:0]  lock;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_func(req_func),
      .req_address(req_address),
      .req_write_data(req_write_data),
`ifdef MEM_ARB_LOCK_EN
      .lock(lock),
`endif
      .grant(grant),
      .done(done),
      .rd_data(rd_data),
      .mem_func(mem_func),
      .mem_execute(mem_execute),
      .mem_address(mem_address),
      .mem_write_data(mem_write_data),
      .mem_ready(mem_ready),
      .mem_read_data(mem_read_data),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Act as memory_unit for one transaction owned by requester who.
   task automatic serve(input int who, input logic [11:0] addr,
                        input logic [15:0] data, input logic [2:0] grant_after);
      int n = 0;
      while (mem_execute !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("exec_seen", mem_execute, 1);
      chk("grant", grant, 32'(3'b001 << who));
      chk("addr", mem_address, addr);
      chk("busy", busy, 1);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("exec_pulse", mem_execute, 0);
      @(negedge clk);
      chk("no_early_done", done, 0);
      mem_read_data = data;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("done", done, 32'(3'b001 << who));
      chk("rd_data", rd_data, data);
      chk("grant_after", grant, grant_after);
      req[who] = 1'b0;
   endtask

   initial begin
      rst            = 1'b0;
      req            = '0;
      req_func       = {2'b10, 2'b11, 2'b01};
      req_address    = {12'h030, 12'h020, 12'h005};
      req_write_data = {16'h3333, 16'h2222, 16'h1111};
      mem_ready      = 1'b1;
      mem_read_data  = '0;
`ifdef MEM_ARB_LOCK_EN
      lock           = '0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_exec", mem_execute, 0);
      chk("rst_rd", rd_data, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single read from requester 0
      req = 3'b001;
      @(negedge clk);
      chk("rd_func", mem_func, 2'b01);
      chk("rd_wdata", mem_write_data, 16'h1111);
      serve(0, 12'h005, 16'hABCD, 3'b000);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("rd_held", rd_data, 16'hABCD);
      chk("addr_held", mem_address, 12'h005);

      // Contention from reset: order 0, 1, 2
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req_address = {12'h030, 12'h020, 12'h010};
      req = 3'b111;
      serve(0, 12'h010, 16'h0100, 3'b000);
      serve(1, 12'h020, 16'h0200, 3'b000);
      serve(2, 12'h030, 16'h0300, 3'b000);

      // Rotation: after 1 completes, 0 goes before 1
      @(negedge clk);
      req = 3'b010;
      serve(1, 12'h020, 16'h0201, 3'b000);
      req = 3'b011;
      serve(0, 12'h010, 16'h0101, 3'b000);
      serve(1, 12'h020, 16'h0202, 3'b000);

      // Memory not ready: no grant while mem_ready is low
      @(negedge clk);
      mem_ready = 1'b0;
      req = 3'b010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("nr_grant", grant, 0);
         chk("nr_exec", mem_execute, 0);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("nr_grant_late", grant, 3'b010);
      serve(1, 12'h020, 16'h0203, 3'b000);

      // Reset during WAIT_DONE
      @(negedge clk);
      req = 3'b001;
      @(negedge clk);
      chk("mid_exec", mem_execute, 1);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      req = 3'b101;
      mem_read_data = 16'hDEAD;
      mem_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("mid_grant", grant, 0);
      chk("mid_busy", busy, 0);
      chk("mid_addr", mem_address, 0);
      chk("mid_rd", rd_data, 0);
      @(negedge clk);
      chk("mid_done", done, 0);
      rst = 1'b1;
      req = 3'b100;
      serve(2, 12'h030, 16'h0301, 3'b000);

`ifdef MEM_ARB_LOCK_EN
      // Requester 1 locks across two transactions
      @(negedge clk);
      req = 3'b001;
      serve(0, 12'h010, 16'h0102, 3'b000);
      req = 3'b111;
      lock = 3'b010;
      serve(1, 12'h020, 16'h0401, 3'b010);
      @(negedge clk);
      req[1] = 1'b1;
      serve(1, 12'h020, 16'h0402, 3'b010);
      lock = 3'b000;
      serve(2, 12'h030, 16'h0403, 3'b000);
      serve(0, 12'h010, 16'h0404, 3'b000);
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares the single memory_unit port between NUM_REQ requesters: traversal unit (0), execute module (1) and a future allocator/GC (2).
- Replaces the static 2:1 memory_mux. Issues one memory transaction at a time to memory_unit, tracks the is_ready handshake, and returns a one-cycle done pulse plus captured read data to the owning requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- ADDR_W, `memory_addr_width, address width.
- DATA_W, `memory_data_width, data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request; held until that requester's done
- req_func  in  2*NUM_REQ  flattened mem func; requester i at [2i+1:2i]
- req_address  in  ADDR_W*NUM_REQ  flattened addresses
- req_write_data  in  DATA_W*NUM_REQ  flattened write data
- grant  out  NUM_REQ  one-hot owner of the current transaction
- done  out  NUM_REQ  one-cycle pulse to the owner when its transaction completes
- rd_data  out  DATA_W  read_data captured at completion; held until the next completion
- mem_func  out  2  to memory_unit func
- mem_execute  out  1  to memory_unit execute; single-cycle pulse
- mem_address  out  ADDR_W  to memory_unit address
- mem_write_data  out  DATA_W  to memory_unit write_data
- mem_ready  in  1  memory_unit is_ready
- mem_read_data  in  DATA_W  memory_unit read_data
- busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0. All outputs are 0: grant, done, rd_data, mem_*, busy.
- State IDLE:
  - If mem_ready=1 and any req bit is set: pick the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch that requester's func, address and write_data into the mem_* registers, set grant one-hot, then go to ISSUE.
  - If mem_ready=0, stay in IDLE with no grant.
- State ISSUE: mem_execute=1 for exactly this one cycle. Go to WAIT_BUSY.
- State WAIT_BUSY: wait for mem_ready=0, which memory_unit guarantees within 2 cycles of execute. Go to WAIT_DONE.
- State WAIT_DONE: on mem_ready=1:
  - capture mem_read_data into rd_data;
  - pulse done[owner] for one cycle;
  - set rr_ptr = (owner+1) mod NUM_REQ;
  - clear grant and go to IDLE.
- Latency: req sampled in IDLE → mem_execute 1 cycle later. done appears 1 cycle after mem_ready returns high. Minimum turnaround between grants is 1 IDLE cycle.
- mem_func, mem_address and mem_write_data are held stable from the ISSUE cycle through WAIT_DONE. They are not cleared on return to IDLE, only overwritten at the next grant.
- Request inputs are sampled only in IDLE. Changes to an owner's inputs after grant are ignored. A req drop by the owner mid-transaction does not abort it: done still pulses.
- Requesters clear req in the cycle done is seen. A req still high one cycle after done is treated as a new request and takes its normal round-robin turn.
- Simultaneous events:
  - A new req arriving in the same cycle as done is arbitrated in the following IDLE cycle.
  - All requesters asserted at once are served in order rr_ptr, rr_ptr+1, and so on.
- Unused req bits (above NUM_REQ) do not exist. NUM_REQ=1 degenerates to a pass-through with handshake.
- Reset mid-transaction: immediate return to IDLE, with no done pulse. The memory transaction in flight is abandoned; memory_unit is reset by the same rst.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- With the macro defined:
  - Add an input port lock (NUM_REQ bits).
  - If lock[owner]=1 at completion, rr_ptr is not advanced and the grant is retained. IDLE only grants that same owner, which waits while its req=0, until lock[owner] drops.
  - This allows atomic read-modify-write sequences by the execute module.
  - lock from a non-owner is ignored.
- Without the macro: there is no lock port and pure round-robin applies.

Test Plan:
- Single read: req=3'b001, func=read, address=0x005, memory returns 0xABCD → mem_execute pulses once with address 0x005; done=3'b001 occurs 1 cycle after mem_ready rises; rd_data=0xABCD.
- Contention: req=3'b111 from reset → grant order is 0, 1, 2. Each mem_execute carries that requester's address. Exactly 3 done pulses occur, in matching order.
- Rotation: after requester 1 completes, assert req=3'b011 → requester 0 is granted only after 2 has been checked; the order is 0 then 1.
- Memory not ready: hold mem_ready=0 with req=3'b010 for 5 cycles → no grant and no mem_execute. Grant follows 1 cycle after mem_ready=1.
- Reset mid-op: pull rst low during WAIT_DONE → the next sample shows all outputs 0 and no done pulse. After release, a pending req=3'b100 is served first, with rr_ptr=0 and bits 0 and 1 idle.
- Lock (MEM_ARB_LOCK_EN): requester 1 holds lock through 2 transactions while req=3'b101 is pending → requester 1 gets both transactions back-to-back, then requester 2, then requester 0.
